// File: rtl/led_seq_pkg.sv
// Shared types and register layout for the LED sequencer.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_ROTATE = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  localparam logic ADDR_CTRL = 1'b0;
  localparam logic ADDR_PAT  = 1'b1;

  localparam int CTRL_MODE_LSB = 0;
  localparam int CTRL_EN_BIT   = 2;
  localparam int CTRL_PER_LSB  = 8;

  localparam int ST_LEDS_LSB  = 0;
  localparam int ST_BTN_LSB   = 8;
  localparam int ST_OVR_BIT   = 12;
  localparam int ST_DIR_BIT   = 13;
  localparam int ST_PHASE_BIT = 14;

  typedef struct packed {
    logic [7:0] period;
    logic       enable;
    mode_e      mode;
  } ctrl_t;

  function automatic logic [31:0] ctrl_pack(input ctrl_t c);
    logic [31:0] r;
    r = '0;
    r[CTRL_MODE_LSB +: 2] = c.mode;
    r[CTRL_EN_BIT]        = c.enable;
    r[CTRL_PER_LSB +: 8]  = c.period;
    return r;
  endfunction

endpackage

// File: rtl/led_sequencer_button_debounce.sv
// Push-button synchronizer and tick-based debouncer; output is 1 while a button is held.
module button_debounce
  import led_seq_pkg::*;
#(
  parameter int WIDTH          = 4,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] pressed
);

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

  logic [WIDTH-1:0]         sync1_q, sync2_q;
  logic [WIDTH-1:0]         deb_q, deb_d;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;

  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      // Raw buttons are active-low, so the synchronized level is inverted here.
      if (~sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == CW'(DEBOUNCE_TICKS - 1)) begin
          deb_d[i] = ~sync2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
      deb_q   <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pressed = deb_q;

endmodule

// File: rtl/led_sequencer.sv
// Avalon-MM LED scheduler: buttons override a pattern engine, which overrides the host pattern.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int TICK_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        avs_s0_address,
  input  logic        avs_s0_read,
  input  logic        avs_s0_write,
  output logic [31:0] avs_s0_readdata,
  input  logic [31:0] avs_s0_writedata,
  input  logic [3:0]  button_in_port,
  output logic [7:0]  leds
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] presc_q, presc_d;
  ctrl_t         ctrl_q, ctrl_d;
  logic [7:0]    pattern_q, pattern_d;
  logic [7:0]    work_q, work_d;
  logic [7:0]    step_cnt_q, step_cnt_d;
  logic [7:0]    leds_q, leds_d;
  logic          dir_q, dir_d;
  logic          phase_q, phase_d;
  logic [31:0]   rdata_q, rdata_d;

  logic        tick, run, step, wr_ctrl, wr_pat;
  logic [3:0]  pressed;
  logic [7:0]  eng;
  logic [31:0] status;
  logic        unused_wd;

  assign unused_wd = ^{avs_s0_writedata[31:16], avs_s0_writedata[7:3]};

  button_debounce #(
    .WIDTH         (4),
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
  ) u_debounce (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick),
    .raw    (button_in_port),
    .pressed(pressed)
  );

  always_comb begin
    wr_ctrl = avs_s0_write && (avs_s0_address == ADDR_CTRL);
    wr_pat  = avs_s0_write && (avs_s0_address == ADDR_PAT);

    tick    = (presc_q == PW'(TICK_DIV - 1));
    presc_d = tick ? '0 : presc_q + PW'(1);

    run  = tick && ctrl_q.enable && (ctrl_q.mode != MODE_STATIC);
    step = run && (step_cnt_q == ctrl_q.period);

    step_cnt_d = step_cnt_q;
    if (wr_ctrl || wr_pat) step_cnt_d = '0;
    else if (run)          step_cnt_d = step ? 8'd0 : step_cnt_q + 8'd1;

    ctrl_d = ctrl_q;
    if (wr_ctrl) begin
      ctrl_d.mode   = mode_e'(avs_s0_writedata[CTRL_MODE_LSB +: 2]);
      ctrl_d.enable = avs_s0_writedata[CTRL_EN_BIT];
      ctrl_d.period = avs_s0_writedata[CTRL_PER_LSB +: 8];
    end

    pattern_d = pattern_q;
    work_d    = work_q;
    dir_d     = dir_q;
    phase_d   = phase_q;
    // A host pattern load takes precedence over a coincident step.
    if (wr_pat) begin
      pattern_d = avs_s0_writedata[7:0];
      work_d    = avs_s0_writedata[7:0];
      dir_d     = 1'b0;
      phase_d   = 1'b1;
    end else if (step) begin
      case (ctrl_q.mode)
        MODE_ROTATE: work_d = {work_q[6:0], work_q[7]};
        MODE_BOUNCE: begin
          if (!dir_q) begin
            if (work_q[7]) begin dir_d = 1'b1; work_d = work_q >> 1; end
            else                 work_d = work_q << 1;
          end else begin
            if (work_q[0]) begin dir_d = 1'b0; work_d = work_q << 1; end
            else                 work_d = work_q >> 1;
          end
        end
        MODE_BLINK: phase_d = ~phase_q;
        default: ;
      endcase
    end

    case (ctrl_q.mode)
      MODE_STATIC: eng = pattern_q;
      MODE_BLINK:  eng = phase_q ? pattern_q : 8'h00;
      default:     eng = work_q;
    endcase

    leds_d = (|pressed) ? {4'b0000, pressed} : eng;

    status = '0;
    status[ST_LEDS_LSB +: 8] = leds_q;
    status[ST_BTN_LSB +: 4]  = pressed;
    status[ST_OVR_BIT]       = |pressed;
    status[ST_DIR_BIT]       = dir_q;
    status[ST_PHASE_BIT]     = phase_q;

    rdata_d = rdata_q;
    if (avs_s0_read) rdata_d = (avs_s0_address == ADDR_CTRL) ? ctrl_pack(ctrl_q) : status;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q    <= '0;
      ctrl_q     <= '0;
      pattern_q  <= '0;
      work_q     <= '0;
      step_cnt_q <= '0;
      leds_q     <= '0;
      dir_q      <= 1'b0;
      phase_q    <= 1'b1;
      rdata_q    <= '0;
    end else begin
      presc_q    <= presc_d;
      ctrl_q     <= ctrl_d;
      pattern_q  <= pattern_d;
      work_q     <= work_d;
      step_cnt_q <= step_cnt_d;
      leds_q     <= leds_d;
      dir_q      <= dir_d;
      phase_q    <= phase_d;
      rdata_q    <= rdata_d;
    end
  end

  assign avs_s0_readdata = rdata_q;
  assign leds            = leds_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench for led_sequencer with a 4-cycle tick and 2-tick debounce.
module tb_led_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        avs_s0_address = 1'b0;
  logic        avs_s0_read = 1'b0;
  logic        avs_s0_write = 1'b0;
  logic [31:0] avs_s0_readdata;
  logic [31:0] avs_s0_writedata = '0;
  logic [3:0]  button_in_port = 4'hF;
  logic [7:0]  leds;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];

  led_sequencer #(
    .TICK_DIV      (4),
    .DEBOUNCE_TICKS(2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .avs_s0_address  (avs_s0_address),
    .avs_s0_read     (avs_s0_read),
    .avs_s0_write    (avs_s0_write),
    .avs_s0_readdata (avs_s0_readdata),
    .avs_s0_writedata(avs_s0_writedata),
    .button_in_port  (button_in_port),
    .leds            (leds)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic bus_write(input logic a, input logic [31:0] d);
    @(negedge clk);
    avs_s0_address = a; avs_s0_writedata = d; avs_s0_write = 1'b1;
    @(posedge clk); #1;
    avs_s0_write = 1'b0;
  endtask

  task automatic bus_read(input logic a, output logic [31:0] d);
    @(negedge clk);
    avs_s0_address = a; avs_s0_read = 1'b1;
    @(posedge clk); #1;
    avs_s0_read = 1'b0;
    d = avs_s0_readdata;
  endtask

  task automatic bus_rw(input logic a, input logic [31:0] wd, output logic [31:0] d);
    @(negedge clk);
    avs_s0_address = a; avs_s0_writedata = wd; avs_s0_read = 1'b1; avs_s0_write = 1'b1;
    @(posedge clk); #1;
    avs_s0_read = 1'b0; avs_s0_write = 1'b0;
    d = avs_s0_readdata;
  endtask

  task automatic wait_change(input logic [7:0] prev, output logic [7:0] val, output int at);
    bit done;
    done = 1'b0; val = prev; at = -1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk); #1;
      if (leds !== prev) begin val = leds; at = cyc; done = 1'b1; end
    end
  endtask

  task automatic test_reset();
    logic [31:0] d, e;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (leds !== 8'h00) begin failures++; $display("FAIL reset_leds got=%h exp=00", leds); end
    checks++;
    if (avs_s0_readdata !== 32'h0) begin failures++; $display("FAIL reset_readdata got=%h exp=0", avs_s0_readdata); end
    exp_q.push_back(32'h0000_0000);
    bus_read(1'b0, d); e = exp_q.pop_front();
    checks++;
    if (d !== e) begin failures++; $display("FAIL reset_ctrl got=%h exp=%h", d, e); end
    exp_q.push_back(32'h0000_4000);
    bus_read(1'b1, d); e = exp_q.pop_front();
    checks++;
    if (d !== e) begin failures++; $display("FAIL reset_status got=%h exp=%h", d, e); end
  endtask

  task automatic test_static();
    logic [31:0] d, e;
    exp_q.push_back(32'h0000_00A5);
    bus_write(1'b1, 32'h0000_00A5);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if (leds !== e[7:0]) begin failures++; $display("FAIL static_leds got=%h exp=%h", leds, e[7:0]); end
    bus_write(1'b0, 32'h0);
    exp_q.push_back(32'h0);
    bus_read(1'b0, d); e = exp_q.pop_front();
    checks++;
    if (d !== e) begin failures++; $display("FAIL static_ctrl_read got=%h exp=%h", d, e); end
    exp_q.push_back(32'h0);
    bus_rw(1'b0, 32'h0000_0100, d); e = exp_q.pop_front();
    checks++;
    if (d !== e) begin failures++; $display("FAIL rw_prewrite got=%h exp=%h", d, e); end
    exp_q.push_back(32'h0000_0100);
    bus_read(1'b0, d); e = exp_q.pop_front();
    checks++;
    if (d !== e) begin failures++; $display("FAIL rw_postwrite got=%h exp=%h", d, e); end
    repeat (3) @(posedge clk); #1;
    checks++;
    if (avs_s0_readdata !== 32'h0000_0100) begin
      failures++; $display("FAIL readdata_hold got=%h exp=00000100", avs_s0_readdata);
    end
    bus_write(1'b0, 32'h0);
  endtask

  task automatic test_rotate();
    logic [31:0] d, e;
    logic [7:0] v;
    int a1, a2;
    bus_write(1'b1, 32'h0000_0081);
    bus_write(1'b0, 32'hFFFF_01FD);
    exp_q.push_back(32'h0000_0105);
    bus_read(1'b0, d); e = exp_q.pop_front();
    checks++;
    if (d !== e) begin failures++; $display("FAIL rotate_ctrl_mask got=%h exp=%h", d, e); end
    checks++;
    if (leds !== 8'h81) begin failures++; $display("FAIL rotate_start got=%h exp=81", leds); end
    exp_q.push_back(32'h03); exp_q.push_back(32'h06);
    wait_change(8'h81, v, a1); e = exp_q.pop_front();
    checks++;
    if (v !== e[7:0]) begin failures++; $display("FAIL rotate_step1 got=%h exp=%h", v, e[7:0]); end
    wait_change(v, v, a2); e = exp_q.pop_front();
    checks++;
    if (v !== e[7:0]) begin failures++; $display("FAIL rotate_step2 got=%h exp=%h", v, e[7:0]); end
    checks++;
    if (a2 - a1 !== 8) begin failures++; $display("FAIL rotate_interval got=%0d exp=8", a2 - a1); end
    bus_write(1'b0, 32'h0000_0101);
    repeat (24) @(posedge clk); #1;
    checks++;
    if (leds !== 8'h06) begin failures++; $display("FAIL rotate_freeze got=%h exp=06", leds); end
  endtask

  task automatic test_bounce();
    logic [31:0] d, e;
    logic [7:0] v;
    int a1, a2;
    bus_write(1'b1, 32'h0000_0040);
    bus_write(1'b0, 32'h0000_0006);
    exp_q.push_back(32'h80); exp_q.push_back(32'h40); exp_q.push_back(32'h6040); exp_q.push_back(32'h20);
    wait_change(8'h40, v, a1); e = exp_q.pop_front();
    checks++;
    if (v !== e[7:0]) begin failures++; $display("FAIL bounce_up got=%h exp=%h", v, e[7:0]); end
    wait_change(v, v, a2); e = exp_q.pop_front();
    checks++;
    if (v !== e[7:0]) begin failures++; $display("FAIL bounce_turn got=%h exp=%h", v, e[7:0]); end
    checks++;
    if (a2 - a1 !== 4) begin failures++; $display("FAIL bounce_interval got=%0d exp=4", a2 - a1); end
    bus_read(1'b1, d); e = exp_q.pop_front();
    checks++;
    if (d !== e) begin failures++; $display("FAIL bounce_status_dir got=%h exp=%h", d, e); end
    wait_change(8'h40, v, a1); e = exp_q.pop_front();
    checks++;
    if (v !== e[7:0]) begin failures++; $display("FAIL bounce_down got=%h exp=%h", v, e[7:0]); end
  endtask

  task automatic test_blink_collision();
    logic [31:0] d, e;
    logic [7:0] v;
    int a1, a2, a3;
    bus_write(1'b0, 32'h0000_0003);
    bus_write(1'b1, 32'h0000_000F);
    @(posedge clk); #1;
    checks++;
    if (leds !== 8'h0F) begin failures++; $display("FAIL blink_idle got=%h exp=0F", leds); end
    bus_write(1'b0, 32'h0000_0007);
    exp_q.push_back(32'h00); exp_q.push_back(32'h0F); exp_q.push_back(32'h400F); exp_q.push_back(32'h00);
    wait_change(8'h0F, v, a1); e = exp_q.pop_front();
    checks++;
    if (v !== e[7:0]) begin failures++; $display("FAIL blink_off got=%h exp=%h", v, e[7:0]); end
    wait_change(v, v, a2); e = exp_q.pop_front();
    checks++;
    if (v !== e[7:0]) begin failures++; $display("FAIL blink_on got=%h exp=%h", v, e[7:0]); end
    checks++;
    if (a2 - a1 !== 4) begin failures++; $display("FAIL blink_interval got=%0d exp=4", a2 - a1); end
    // leds changed one cycle after a step; the next step lands three edges later.
    repeat (2) @(posedge clk);
    bus_write(1'b1, 32'h0000_000F);
    bus_read(1'b1, d); e = exp_q.pop_front();
    checks++;
    if (d !== e) begin failures++; $display("FAIL collision_status got=%h exp=%h", d, e); end
    wait_change(8'h0F, v, a3); e = exp_q.pop_front();
    checks++;
    if (v !== e[7:0]) begin failures++; $display("FAIL collision_next got=%h exp=%h", v, e[7:0]); end
    checks++;
    if (a3 - a2 !== 8) begin failures++; $display("FAIL collision_interval got=%0d exp=8", a3 - a2); end
  endtask

  task automatic test_buttons();
    logic [31:0] d, e;
    bit ok;
    bus_write(1'b0, 32'h0);
    bus_write(1'b1, 32'h0000_000F);
    @(posedge clk);
    // One-tick glitch on button 0 must never reach the LEDs.
    @(negedge clk); button_in_port = 4'b1110;
    repeat (4) @(negedge clk);
    button_in_port = 4'b1111;
    ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (leds !== 8'h0F) ok = 1'b0;
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL glitch_ignored got=%h exp=0F", leds); end
    exp_q.push_back(32'h02); exp_q.push_back(32'h5202);
    @(negedge clk); button_in_port = 4'b1101;
    repeat (16) @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if (leds !== e[7:0]) begin failures++; $display("FAIL press_leds got=%h exp=%h", leds, e[7:0]); end
    bus_read(1'b1, d); e = exp_q.pop_front();
    checks++;
    if (d !== e) begin failures++; $display("FAIL press_status got=%h exp=%h", d, e); end
    exp_q.push_back(32'h0F); exp_q.push_back(32'h400F);
    @(negedge clk); button_in_port = 4'b1111;
    repeat (16) @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if (leds !== e[7:0]) begin failures++; $display("FAIL release_leds got=%h exp=%h", leds, e[7:0]); end
    bus_read(1'b1, d); e = exp_q.pop_front();
    checks++;
    if (d !== e) begin failures++; $display("FAIL release_status got=%h exp=%h", d, e); end
    @(negedge clk); button_in_port = 4'b1101;
    repeat (16) @(posedge clk); #1;
    checks++;
    if (leds !== 8'h02) begin failures++; $display("FAIL repress_leds got=%h exp=02", leds); end
    @(negedge clk); #2 reset = 1'b1;
    #1;
    checks++;
    if (leds !== 8'h00) begin failures++; $display("FAIL async_reset_leds got=%h exp=00", leds); end
    checks++;
    if (avs_s0_readdata !== 32'h0) begin failures++; $display("FAIL async_reset_rdata got=%h exp=0", avs_s0_readdata); end
    repeat (3) @(negedge clk);
    reset = 1'b0; button_in_port = 4'b1111;
    exp_q.push_back(32'h4000);
    bus_read(1'b1, d); e = exp_q.pop_front();
    checks++;
    if (d !== e) begin failures++; $display("FAIL post_reset_status got=%h exp=%h", d, e); end
  endtask

  initial begin
    test_reset();
    test_static();
    test_rotate();
    test_bounce();
    test_blink_collision();
    test_buttons();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- Avalon-MM-controlled scheduler that owns the board's 8 user LEDs and arbitrates them between three sources: host static pattern, hardware pattern engine, and the local push-buttons.
- Sits in the soc_system fabric as a lightweight-bridge slave beside the existing LED/GPIO peripheral.
- Drives the `leds` top-level output directly.
- Priority is fixed: buttons first, then the pattern engine, then the host static value.

Parameters:
- TICK_DIV, 50000: clk cycles per time-base tick (1 ms at 50 MHz); must be ≥ 2.
- DEBOUNCE_TICKS, 20: ticks a synchronized button level must be stable before it is accepted; must be ≥ 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- avs_s0_address  in  1  0 = CTRL, 1 = PATTERN/STATUS.
- avs_s0_read  in  1  read strobe.
- avs_s0_write  in  1  write strobe.
- avs_s0_readdata  out  32  read data, readLatency 1.
- avs_s0_writedata  in  32  write data.
- button_in_port  in  4  raw push-buttons, active-low, asynchronous.
- leds  out  8  LED drive, 1 = on, registered.

Behaviour:
- Reset state:
  - All outputs 0: leds=0, readdata=0.
  - Registers: CTRL=0, PATTERN=0, work=0, dir=0, phase=1.
  - Counters: prescaler=0, step_cnt=0.
  - Debounced buttons all released; sync flops =1.
  - Reset mid-operation returns to this state immediately (async assert); normal operation resumes on the first clk after deassert.
- CTRL register (addr 0, R/W):
  - [1:0] mode: 0 STATIC, 1 ROTATE, 2 BOUNCE, 3 BLINK.
  - [2] enable.
  - [15:8] period, in ticks per step.
  - Other bits write-ignored, read 0.
  - Any CTRL write clears step_cnt.
- PATTERN write (addr 1): pattern<=wd[7:0], work<=wd[7:0], dir<=0, phase<=1, step_cnt<=0.
- STATUS read (addr 1):
  - [7:0] current leds.
  - [11:8] debounced pressed mask.
  - [12] override active.
  - [13] dir.
  - [14] phase.
  - Rest 0.
- Readdata is registered one cycle after the read strobe and holds its value otherwise.
- If read and write fall in the same cycle, the read returns the pre-write value.
- Time base:
  - Prescaler counts 0..TICK_DIV-1; a 1-cycle tick pulses at wrap.
- Step generation:
  - On a tick with enable=1 and mode≠STATIC: if step_cnt==period, issue a step and clear step_cnt; else increment step_cnt.
  - period=0 means a step every tick.
  - When enable=0, the engine freezes (work, dir, phase, step_cnt held).
- Step actions:
  - ROTATE: work rotates left 1.
  - BOUNCE:
    - dir=0: if work[7], set dir=1 and work>>=1; else work<<=1.
    - dir=1: if work[0], set dir=0 and work<<=1; else work>>=1.
    - Zero-fill; bits may be lost with multi-bit patterns.
    - work=0 stays 0.
  - BLINK: phase toggles.
- A PATTERN write in the same cycle as a step wins; that step is dropped.
- Engine output:
  - STATIC: pattern.
  - ROTATE/BOUNCE: work.
  - BLINK: phase ? pattern : 0.
- Buttons:
  - 2-flop synchronizer per bit (active-low inverted to pressed=1).
  - Per-bit counter counts ticks while the sync level ≠ the debounced level; it resets on match.
  - At DEBOUNCE_TICKS the debounced level updates.
- Override:
  - Active when any debounced bit is pressed; then leds = {4'b0, pressed[3:0]}.
  - The engine keeps running underneath.
  - On release, leds shows the engine value again on the next cycle.
- leds update one cycle after the source change, registered.

Decomposition:
- Package led_seq_pkg holds:
  - mode enum (MODE_STATIC..MODE_BLINK).
  - Address constants ADDR_CTRL/ADDR_PAT.
  - CTRL/STATUS bit-field position localparams.
  - CTRL packed struct.
- Sub-module button_debounce (parameter WIDTH=4, DEBOUNCE_TICKS; inputs clk, reset, tick, raw; output pressed).
  - Instantiated once.
  - Contains synchronizer and per-bit counters.

Test Plan:
(TICK_DIV=4, DEBOUNCE_TICKS=2 in all scenarios.)
- Reset: release reset -> leds=0; read addr 0 gives 0; read addr 1 gives 0x0000_4000 (phase=1).
- STATIC: write addr1=0xA5 -> leds=0xA5 within 2 cycles; read addr0 after writing 0x0000_0000 -> readdata 0 one cycle after the read.
- ROTATE: write PATTERN=0x81, then CTRL=0x0000_0105 (period 1, enable, rotate) -> leds 0x81→0x03→0x06 every 2 ticks (8 clk); clearing enable freezes the value.
- BOUNCE: PATTERN=0x40, CTRL=0x0006 (period 0) -> per tick 0x40→0x80→0x40→0x20; STATUS[13] sets at the 0x80→0x40 step.
- BLINK + write collision: PATTERN=0x0F, CTRL=0x0007 -> leds alternate 0x0F/0x00 per tick; a PATTERN=0x0F write on a step cycle keeps phase=1 (no toggle).
- Buttons:
  - Drive button_in_port=4'b1101 for ≥ 3 ticks -> leds=0x02, STATUS[12]=1.
  - 1-tick glitches are ignored.
  - Release -> engine value returns.
  - Assert reset mid-press -> leds=0 immediately.
